// File: rtl/ee354_project_dirn_queue.sv
// ee354_project_dirn_queue
//   Buffers debounced direction presses and releases at most one direction
//   per snake step. Redundant presses (equal to the newest known direction)
//   are always dropped. 180-degree reversals are dropped only when
//   DIRN_QUEUE_REVERSAL_FILTER_EN is defined; otherwise they are queued.
//
// Ports
//   Clk        : system clock
//   Reset      : asynchronous active-high reset
//   Btn*_SCEN  : single-cycle debounced press pulses (priority U > D > L > R)
//   Speed_Clk  : slow game-speed clock, synchronized and edge-detected as data
//   q_Run      : game running; when low the queue is flushed every cycle
//   Cur_Dirn   : direction for the current step (00 U, 01 D, 10 L, 11 R)
//   Step       : one-cycle pulse per Speed_Clk rising edge while running
//   Count      : number of queued entries
//   Overflow   : one-cycle pulse when a valid press is lost to a full queue
module ee354_project_dirn_queue #(
  parameter int         DEPTH     = 4,
  parameter logic [1:0] INIT_DIRN = 2'b11
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     BtnU_SCEN,
  input  logic                     BtnD_SCEN,
  input  logic                     BtnL_SCEN,
  input  logic                     BtnR_SCEN,
  input  logic                     Speed_Clk,
  input  logic                     q_Run,
  output logic [1:0]               Cur_Dirn,
  output logic                     Step,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [1:0]    mem_q [DEPTH];
  logic [1:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    cur_dirn_q, cur_dirn_d;
  logic          step_q, step_d;
  logic          overflow_q, overflow_d;
  logic          sync1_q, sync2_q, sync3_q;
  logic          tick_q, tick_d;

  logic          press_vld;
  logic [1:0]    press_dirn;
  logic [1:0]    ref_dirn;
  logic          redundant;
  logic          rev_drop;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          push;

  always_comb begin
    press_vld  = BtnU_SCEN | BtnD_SCEN | BtnL_SCEN | BtnR_SCEN;
    press_dirn = 2'b11;
    if (BtnU_SCEN)      press_dirn = 2'b00;
    else if (BtnD_SCEN) press_dirn = 2'b01;
    else if (BtnL_SCEN) press_dirn = 2'b10;

    // Newest known direction: queue tail if anything is pending, else current.
    ref_dirn  = (count_q != '0) ? mem_q[wr_ptr_q - AW'(1)] : cur_dirn_q;
    redundant = (press_dirn == ref_dirn);
`ifdef DIRN_QUEUE_REVERSAL_FILTER_EN
    rev_drop  = (press_dirn[1] == ref_dirn[1]) && (press_dirn[0] != ref_dirn[0]);
`else
    rev_drop  = 1'b0;
`endif

    full    = (count_q == CW'(DEPTH));
    pop     = q_Run & tick_q & (count_q != '0);
    push_ok = q_Run & press_vld & ~redundant & ~rev_drop;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    push    = push_ok & (~full | pop);
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    cur_dirn_d = cur_dirn_q;
    step_d     = 1'b0;
    overflow_d = 1'b0;
    tick_d     = sync2_q & ~sync3_q;

    if (!q_Run) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      cur_dirn_d = INIT_DIRN;
    end else begin
      step_d     = tick_q;
      overflow_d = push_ok & full & ~pop;
      if (pop) begin
        cur_dirn_d = mem_q[rd_ptr_q];
        rd_ptr_d   = rd_ptr_q + AW'(1);
      end
      if (push) begin
        mem_d[wr_ptr_q] = press_dirn;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cur_dirn_q <= INIT_DIRN;
      step_q     <= 1'b0;
      overflow_q <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cur_dirn_q <= cur_dirn_d;
      step_q     <= step_d;
      overflow_q <= overflow_d;
      sync1_q    <= Speed_Clk;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      tick_q     <= tick_d;
    end
  end

  assign Cur_Dirn = cur_dirn_q;
  assign Step     = step_q;
  assign Count    = count_q;
  assign Overflow = overflow_q;

endmodule

// File: tb/tb_ee354_project_dirn_queue.sv
module tb_ee354_project_dirn_queue;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       BtnU_SCEN, BtnD_SCEN, BtnL_SCEN, BtnR_SCEN;
  logic       Speed_Clk;
  logic       q_Run;
  logic [1:0] Cur_Dirn;
  logic       Step;
  logic [2:0] Count;
  logic       Overflow;

  int passed = 0;
  int total  = 0;

  ee354_project_dirn_queue #(.DEPTH(4), .INIT_DIRN(2'b11)) dut (
    .Clk(Clk), .Reset(Reset),
    .BtnU_SCEN(BtnU_SCEN), .BtnD_SCEN(BtnD_SCEN),
    .BtnL_SCEN(BtnL_SCEN), .BtnR_SCEN(BtnR_SCEN),
    .Speed_Clk(Speed_Clk), .q_Run(q_Run),
    .Cur_Dirn(Cur_Dirn), .Step(Step), .Count(Count), .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One-cycle press pulse; buttons are one-hot string "UDLR" encoded as 4 bits.
  task automatic press(input logic [3:0] udlr);
    {BtnU_SCEN, BtnD_SCEN, BtnL_SCEN, BtnR_SCEN} = udlr;
    @(negedge Clk);
    {BtnU_SCEN, BtnD_SCEN, BtnL_SCEN, BtnR_SCEN} = 4'b0000;
  endtask

  // Speed_Clk rise at a negedge; Step expected after the 4th following negedge.
  task automatic tick_chk(input string tag, input logic [1:0] exp_dirn, input logic [7:0] exp_cnt);
    Speed_Clk = 1'b1;
    repeat (3) @(negedge Clk);
    chk({tag, "_step_early"}, {7'b0, Step}, 8'd0);
    @(negedge Clk);
    chk({tag, "_step"}, {7'b0, Step}, 8'd1);
    chk({tag, "_dirn"}, {6'b0, Cur_Dirn}, {6'b0, exp_dirn});
    chk({tag, "_count"}, {5'b0, Count}, exp_cnt);
    @(negedge Clk);
    Speed_Clk = 1'b0;
    chk({tag, "_step_width"}, {7'b0, Step}, 8'd0);
    repeat (5) begin
      @(negedge Clk);
      chk({tag, "_no_fall_step"}, {7'b0, Step}, 8'd0);
    end
  endtask

  initial begin
    Reset = 1'b1; q_Run = 1'b0; Speed_Clk = 1'b0;
    {BtnU_SCEN, BtnD_SCEN, BtnL_SCEN, BtnR_SCEN} = 4'b0000;
    #2;
    chk("rst_count", {5'b0, Count}, 8'd0);
    chk("rst_dirn", {6'b0, Cur_Dirn}, 8'h3);
    chk("rst_step", {7'b0, Step}, 8'd0);
    chk("rst_ovf", {7'b0, Overflow}, 8'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    // Not running: Speed_Clk toggles and presses are ignored.
    Speed_Clk = 1'b1;
    repeat (6) begin
      @(negedge Clk);
      chk("idle_step", {7'b0, Step}, 8'd0);
    end
    Speed_Clk = 1'b0;
    press(4'b1000);
    chk("idle_press_count", {5'b0, Count}, 8'd0);
    chk("idle_dirn", {6'b0, Cur_Dirn}, 8'h3);
    repeat (4) @(negedge Clk);

    // Running: U then L, popped on consecutive ticks.
    q_Run = 1'b1;
    @(negedge Clk);
    press(4'b1000);
    chk("push_u_count", {5'b0, Count}, 8'd1);
    press(4'b0010);
    chk("push_l_count", {5'b0, Count}, 8'd2);
    tick_chk("tick1", 2'b00, 8'd1);
    tick_chk("tick2", 2'b10, 8'd0);
    tick_chk("tick_empty", 2'b10, 8'd0);

    // Redundant press (L while heading L) dropped.
    press(4'b0010);
    chk("redundant_count", {5'b0, Count}, 8'd0);

    // U and R together from Ref=10: only U (00) queued.
    press(4'b1001);
    chk("coincide_count", {5'b0, Count}, 8'd1);
    press(4'b0010);
    press(4'b1000);
    press(4'b0010);
    chk("fill_count", {5'b0, Count}, 8'd4);
    chk("fill_ovf", {7'b0, Overflow}, 8'd0);
    press(4'b1000);
    chk("ovf_pulse", {7'b0, Overflow}, 8'd1);
    chk("ovf_count", {5'b0, Count}, 8'd4);
    @(negedge Clk);
    chk("ovf_width", {7'b0, Overflow}, 8'd0);

    // Queue 00,10,00,10 (tail 10); press U in the tick cycle -> accepted.
    Speed_Clk = 1'b1;
    repeat (3) @(negedge Clk);
    press(4'b1000);
    chk("pp_step", {7'b0, Step}, 8'd1);
    chk("pp_dirn", {6'b0, Cur_Dirn}, 8'h0);
    chk("pp_count", {5'b0, Count}, 8'd4);
    chk("pp_ovf", {7'b0, Overflow}, 8'd0);
    @(negedge Clk);
    Speed_Clk = 1'b0;
    repeat (5) @(negedge Clk);

    // Drop q_Run: flush and reload INIT_DIRN.
    q_Run = 1'b0;
    @(negedge Clk);
    chk("flush_count", {5'b0, Count}, 8'd0);
    chk("flush_dirn", {6'b0, Cur_Dirn}, 8'h3);
    q_Run = 1'b1;
    @(negedge Clk);

    // Reversal: L while heading R.
    press(4'b0010);
`ifdef DIRN_QUEUE_REVERSAL_FILTER_EN
    chk("rev_count", {5'b0, Count}, 8'd0);
    tick_chk("rev_tick", 2'b11, 8'd0);
`else
    chk("rev_count", {5'b0, Count}, 8'd1);
    tick_chk("rev_tick", 2'b10, 8'd0);
`endif

    // Mid-run asynchronous reset during a Step pulse with Count=3.
    press(4'b1000);
    press(4'b0010);
    press(4'b1000);
    press(4'b0010);
    chk("pre_rst_count", {5'b0, Count}, 8'd4);
    Speed_Clk = 1'b1;
    repeat (4) @(negedge Clk);
    chk("pre_rst_step", {7'b0, Step}, 8'd1);
    chk("pre_rst_count3", {5'b0, Count}, 8'd3);
    chk("pre_rst_dirn", {6'b0, Cur_Dirn}, 8'h0);
    #2 Reset = 1'b1;
    #1;
    chk("async_rst_count", {5'b0, Count}, 8'd0);
    chk("async_rst_dirn", {6'b0, Cur_Dirn}, 8'h3);
    chk("async_rst_step", {7'b0, Step}, 8'd0);
    chk("async_rst_ovf", {7'b0, Overflow}, 8'd0);
    Speed_Clk = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    chk("post_rst_count", {5'b0, Count}, 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ee354_project_dirn_queue.md
# ee354_project_dirn_queue

Buffers debounced direction presses from the four direction buttons and releases at most one direction per snake step. Sits between the button debouncers and the snake length/position stage, replacing the raw `In_Dirn`/`SCEN` mux. Filters redundant presses and, optionally, 180° reversals. Several quick presses between steps (e.g. a U-turn as UP then LEFT) therefore take effect on consecutive steps instead of being lost.

## Interface
- `DEPTH`, 4: queue entries; power of two, 2..16.
- `INIT_DIRN`, 2'b11: direction loaded while not running (RIGHT).
- `Clk` in 1: system clock (100 MHz `sys_clk`).
- `Reset` in 1: one clock; reset is asynchronous and active-high.
- `BtnU_SCEN`, `BtnD_SCEN`, `BtnL_SCEN`, `BtnR_SCEN` in 1 each: single-cycle debounced press pulses.
- `Speed_Clk` in 1: slow game-speed clock (`DIV_CLK[24]`); sampled as data, never used as a clock.
- `q_Run` in 1: game-running state from the state machine.
- `Cur_Dirn` out 2: direction for the current step. Encoding: 00 UP, 01 DOWN, 10 LEFT, 11 RIGHT.
- `Step` out 1: one-cycle pulse; the snake advances one cell using `Cur_Dirn`.
- `Count` out $clog2(DEPTH)+1: number of queued entries.
- `Overflow` out 1: one-cycle pulse when an accepted press is lost because the queue is full.

## Operation
- Press select: priority U > D > L > R when SCEN pulses coincide. Only one press is considered per cycle.
- Reference direction `Ref`:
  - The tail (newest) queue entry if `Count`>0.
  - Otherwise `Cur_Dirn`.
- Press evaluation, in order:
  - If the press equals `Ref`, it is dropped silently (redundant).
  - If it is a reversal of `Ref` (same bit1, different bit0), it is dropped; see Configuration.
  - If the queue is full and no pop happens this cycle, it is dropped and `Overflow` pulses.
  - Otherwise the press is pushed at the tail.
- Tick generation:
  - `Speed_Clk` passes through a 2-flop synchronizer, then a third flop for edge detect.
  - `Tick` = sync2 & ~sync3.
- On `Tick` with `q_Run`=1:
  - If `Count`>0, the head is popped into `Cur_Dirn`.
  - Otherwise `Cur_Dirn` holds.
  - `Step` pulses in either case.
- Simultaneous push and pop:
  - Both happen in the same cycle and `Count` is unchanged.
  - `Ref` is evaluated before the pop.
  - A push into a full queue succeeds when a pop occurs in the same cycle.
- While `q_Run`=0, every cycle:
  - The queue is flushed (`Count`=0).
  - `Cur_Dirn` is set to `INIT_DIRN`.
  - Presses are ignored, and `Step` and `Overflow` stay 0.
- Storage is a circular buffer with `DEPTH` entries of 2 bits. Read and write pointers are $clog2(DEPTH) bits and wrap modulo `DEPTH`.

## Timing
- Reset values:
  - `Cur_Dirn`=`INIT_DIRN`; `Step`=0; `Count`=0; `Overflow`=0.
  - Pointers 0; all synchronizer flops 0.
- Reset may assert mid-operation. It clears everything immediately and asynchronously, with no partial step.
- Tick latency: `Speed_Clk` rises before edge n. `Step` and the new `Cur_Dirn` are visible after edge n+3. Both are registered and change on the same edge.
- Push latency: an SCEN pulse in cycle k updates `Count` and the tail after edge k+1.
- `Step` is exactly one cycle wide, once per `Speed_Clk` rising edge. No `Step` is generated on the falling edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `DIRN_QUEUE_REVERSAL_FILTER_EN`
  - Defined: reversal presses relative to `Ref` are dropped with no `Overflow`.
  - Undefined: reversals are queued like any other press, and the downstream collision logic ends the game.
  - The redundant-press filter is always active.

## Test plan
- Reset asserted mid-run with `Count`=3 -> `Count`=0, `Cur_Dirn`=11, `Step`=0 immediately, without waiting for a clock edge.
- `q_Run`=1, `Cur_Dirn`=11; press U, then L between ticks -> `Count`=2. The next two ticks give `Cur_Dirn` 00 then 10, and `Count` ends at 0.
- `Cur_Dirn`=11; press L with the macro defined -> `Count` stays 0. With the macro undefined -> `Count`=1, and the next tick gives `Cur_Dirn`=10.
- `DEPTH`=4, alternate U/L presses:
  - 5 presses -> the 5th raises `Overflow` for 1 cycle and `Count`=4.
  - The 5th press issued in the `Tick` cycle -> it is accepted with no `Overflow`, and `Count` stays 4.
- `BtnU_SCEN` and `BtnR_SCEN` in the same cycle from `Ref`=10 -> only 00 is queued.
- Toggle `Speed_Clk` with `q_Run`=0 -> no `Step`, `Cur_Dirn`=11. Raise `q_Run` -> the first `Step` comes 3 edges after the next `Speed_Clk` rise.
